// File: rtl/dsi_hs_lanes_ctrl.sv
// dsi_hs_lanes_ctrl: sequences one HS clock lane and LANES HS data lanes for
// one HS burst per packet. Starts the clock lane, waits a pre-delay, starts
// all data lanes together, streams packet beats (one byte per lane per
// cycle), finishes the data lanes, waits a post-delay and stops the clock lane.
module dsi_hs_lanes_ctrl #(
  parameter int LANES           = 2,
  parameter int CLK_PRE_CYCLES  = 4,
  parameter int CLK_POST_CYCLES = 3
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  // upstream packet beats
  input  logic [8*LANES-1:0] tx_data,
  input  logic               tx_valid,
  input  logic               tx_last,
  output logic               tx_ready,
  output logic               busy,
  output logic               underrun_err,
  // clock lane
  output logic               clk_start_rqst,
  output logic               clk_fin_rqst,
  input  logic               clk_data_rqst,
  input  logic               clk_active,
  input  logic               clk_fin_ack,
  output logic [7:0]         clk_lane_data,
  // data lanes
  output logic               data_start_rqst,
  output logic               data_fin_rqst,
  input  logic [LANES-1:0]   data_rqst,
  input  logic [LANES-1:0]   data_active,
  output logic [8*LANES-1:0] lane_data
);

  typedef enum logic [2:0] {
    IDLE,
    CLK_START,
    CLK_PRE,
    DATA_START,
    STREAM,
    DATA_WAIT,
    CLK_POST,
    CLK_FIN
  } state_t;

  // Counter reload values; a delay of one cycle skips the counting state.
  localparam logic [7:0] PRE_LOAD  = 8'(CLK_PRE_CYCLES - 1);
  localparam logic [7:0] POST_LOAD = 8'(CLK_POST_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       drq_q, drq_d;
  logic       clk_fin_q, clk_fin_d;

  logic       consume;
  logic       beat_ok;
  logic       unused_drq;

  // Lanes run in lock-step, so only lane 0 paces the stream; the other
  // request bits are intentionally ignored.
  assign unused_drq = ^data_rqst;

  // A consume cycle is a lane ACTIVE cycle: data_rqst high for the second
  // (or later) consecutive cycle. The first data_rqst cycle is SYNC.
  assign consume = (state_q == STREAM) && data_rqst[0] && drq_q;
  assign beat_ok = consume && tx_valid;

  // State, delay counter, delayed lane-0 request and finish pulse registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drq_q     <= 1'b0;
      clk_fin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drq_q     <= drq_d;
      clk_fin_q <= clk_fin_d;
    end
  end

  // Next-state logic and the request pulses tied to state transitions.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    drq_d          = (state_q == STREAM) && data_rqst[0];
    clk_start_rqst = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid && !clk_active) begin
          clk_start_rqst = 1'b1;
          state_d        = CLK_START;
        end
      end

      CLK_START: begin
        if (clk_data_rqst) begin
          cnt_d   = PRE_LOAD;
          state_d = (PRE_LOAD == 8'd0) ? DATA_START : CLK_PRE;
        end
      end

      CLK_PRE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = DATA_START;
        end
      end

      DATA_START: begin
        state_d = STREAM;
      end

      STREAM: begin
        if (beat_ok && tx_last) begin
          state_d = DATA_WAIT;
        end
      end

      DATA_WAIT: begin
        // Wait for every lane to leave HS, not merely acknowledge finish.
        if (data_active == '0) begin
          cnt_d   = POST_LOAD;
          state_d = (POST_LOAD == 8'd0) ? CLK_FIN : CLK_POST;
        end
      end

      CLK_POST: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = CLK_FIN;
        end
      end

      CLK_FIN: begin
        if (clk_fin_ack || !clk_active) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Clock-lane finish is a single pulse on entry to CLK_FIN, even if the
    // lane takes several cycles to acknowledge.
    clk_fin_d = (state_d == CLK_FIN) && (state_q != CLK_FIN);
  end

  // Datapath and status outputs.
  always_comb begin
    tx_ready        = beat_ok;
    lane_data       = beat_ok ? tx_data : '0;
    data_fin_rqst   = beat_ok && tx_last;
    underrun_err    = consume && !tx_valid;
    data_start_rqst = (state_q == DATA_START);
    clk_fin_rqst    = clk_fin_q;
    busy            = (state_q != IDLE);
    clk_lane_data   = 8'b0101_0101;
  end

endmodule

// File: tb/tb_dsi_hs_lanes_ctrl.sv
// Testbench for dsi_hs_lanes_ctrl: a LANES=2 instance driven through packet
// scenarios against behavioural lane models and a beat scoreboard, plus a
// LANES=1 instance with minimum pre/post delays driven step by step.
module tb_dsi_hs_lanes_ctrl;

  logic        clk_sys;
  logic        rst_n;

  // Instance A: LANES=2, PRE=4, POST=3
  logic [15:0] tx_data;
  logic        tx_valid, tx_last, tx_ready, busy, underrun_err;
  logic        clk_start_rqst, clk_fin_rqst, clk_data_rqst, clk_active, clk_fin_ack;
  logic [7:0]  clk_lane_data;
  logic        data_start_rqst, data_fin_rqst;
  logic [1:0]  data_rqst, data_active;
  logic [15:0] lane_data;

  // Instance B: LANES=1, PRE=1, POST=1
  logic [7:0]  b_tx_data;
  logic        b_tx_valid, b_tx_last, b_tx_ready, b_busy, b_underrun_err;
  logic        b_clk_start_rqst, b_clk_fin_rqst, b_clk_data_rqst, b_clk_active, b_clk_fin_ack;
  logic [7:0]  b_clk_lane_data;
  logic        b_data_start_rqst, b_data_fin_rqst;
  logic [0:0]  b_data_rqst, b_data_active;
  logic [7:0]  b_lane_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [16:0] exp_q[$];
  int n_cstart, n_dstart, n_cfin, n_rdy, first_rdy, last_rdy, n_under;
  int t_cdr, t_dstart, t_dfall, t_cfin, t_fack, t_idle;
  logic cdr_prev = 1'b0;
  logic [1:0] dact_prev = 2'b00;
  logic wait_restart = 1'b0;

  dsi_hs_lanes_ctrl #(.LANES(2), .CLK_PRE_CYCLES(4), .CLK_POST_CYCLES(3)) dut_a (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .underrun_err(underrun_err),
    .clk_start_rqst(clk_start_rqst), .clk_fin_rqst(clk_fin_rqst),
    .clk_data_rqst(clk_data_rqst), .clk_active(clk_active), .clk_fin_ack(clk_fin_ack),
    .clk_lane_data(clk_lane_data),
    .data_start_rqst(data_start_rqst), .data_fin_rqst(data_fin_rqst),
    .data_rqst(data_rqst), .data_active(data_active), .lane_data(lane_data)
  );

  dsi_hs_lanes_ctrl #(.LANES(1), .CLK_PRE_CYCLES(1), .CLK_POST_CYCLES(1)) dut_b (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_last(b_tx_last), .tx_ready(b_tx_ready),
    .busy(b_busy), .underrun_err(b_underrun_err),
    .clk_start_rqst(b_clk_start_rqst), .clk_fin_rqst(b_clk_fin_rqst),
    .clk_data_rqst(b_clk_data_rqst), .clk_active(b_clk_active), .clk_fin_ack(b_clk_fin_ack),
    .clk_lane_data(b_clk_lane_data),
    .data_start_rqst(b_data_start_rqst), .data_fin_rqst(b_data_fin_rqst),
    .data_rqst(b_data_rqst), .data_active(b_data_active), .lane_data(b_lane_data)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural lane models for instance A (registered responses).
  int c_dly, f_dly, d_dly, e_dly;
  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_active <= 1'b0; clk_data_rqst <= 1'b0; clk_fin_ack <= 1'b0;
      data_rqst <= '0; data_active <= '0;
      c_dly <= 0; f_dly <= 0; d_dly <= 0; e_dly <= 0;
    end else begin
      clk_fin_ack <= 1'b0;
      if (clk_start_rqst) c_dly <= 3;
      else if (c_dly != 0) begin
        c_dly <= c_dly - 1;
        if (c_dly == 2) clk_active <= 1'b1;
        if (c_dly == 1) clk_data_rqst <= 1'b1;
      end
      if (clk_fin_rqst) f_dly <= 2;
      else if (f_dly != 0) begin
        f_dly <= f_dly - 1;
        if (f_dly == 1) begin
          clk_fin_ack <= 1'b1; clk_active <= 1'b0; clk_data_rqst <= 1'b0;
        end
      end
      if (data_start_rqst) d_dly <= 2;
      else if (d_dly != 0) begin
        d_dly <= d_dly - 1;
        if (d_dly == 1) begin data_active <= 2'b11; data_rqst <= 2'b11; end
      end
      if (data_fin_rqst) begin data_rqst <= 2'b00; e_dly <= 2; end
      else if (e_dly != 0) begin
        e_dly <= e_dly - 1;
        if (e_dly == 1) data_active <= 2'b00;
      end
    end
  end

  // Monitor for instance A: event timestamps and scoreboard.
  always @(negedge clk_sys) begin
    logic [16:0] e;
    if (clk_start_rqst) n_cstart++;
    if (data_start_rqst) begin n_dstart++; t_dstart = cyc; end
    if (clk_fin_rqst) begin n_cfin++; t_cfin = cyc; end
    if (clk_fin_ack) t_fack = cyc;
    if (underrun_err) n_under++;
    if (clk_data_rqst && !cdr_prev) t_cdr = cyc;
    cdr_prev = clk_data_rqst;
    if (data_active == 2'b00 && dact_prev != 2'b00) t_dfall = cyc;
    dact_prev = data_active;
    if (tx_ready) begin
      n_rdy++;
      if (first_rdy < 0) first_rdy = cyc;
      last_rdy = cyc;
      chk("ready_before_restart", wait_restart, 1'b0);
      chk("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("lane_data", lane_data, e[15:0]);
        chk("data_fin_rqst", data_fin_rqst, e[16]);
      end
      if (data_fin_rqst) wait_restart = 1'b1;
    end else if (data_rqst[0]) begin
      chk("no_byte_without_ready", lane_data, 16'h0000);
    end
    if (clk_start_rqst) wait_restart = 1'b0;
  end

  task automatic clr_stats();
    n_cstart = 0; n_dstart = 0; n_cfin = 0; n_rdy = 0; n_under = 0;
    first_rdy = -1; last_rdy = -1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last);
    int n = 0;
    tx_data = d; tx_valid = 1'b1; tx_last = last;
    exp_q.push_back({last, d});
    @(negedge clk_sys);
    while (!tx_ready && n < 300) begin @(negedge clk_sys); n++; end
    chk("beat_accepted", tx_ready, 1'b1);
    @(posedge clk_sys); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_sys);
    while (busy && n < 400) begin @(negedge clk_sys); n++; end
    t_idle = cyc;
    chk("idle_reached", busy, 1'b0);
    @(posedge clk_sys); #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    tx_data = '0; tx_valid = 1'b0; tx_last = 1'b0;
    b_tx_data = '0; b_tx_valid = 1'b0; b_tx_last = 1'b0;
    b_clk_data_rqst = 1'b0; b_clk_active = 1'b0; b_clk_fin_ack = 1'b0;
    b_data_rqst = '0; b_data_active = '0;
    clr_stats();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_clk_fin", clk_fin_rqst, 1'b0);
    chk("rst_clk_lane_data", clk_lane_data, 8'h55);
    chk("rst_lane_data", lane_data, 16'h0000);
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    @(posedge clk_sys); #1;

    // Single beat: timing of every request
    clr_stats();
    send_beat(16'hA1B2, 1'b1);
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_idle();
    chk("t1_clk_start_cycles", n_cstart, 1);
    chk("t1_data_start_cycles", n_dstart, 1);
    chk("t1_pre_delay", t_dstart - t_cdr, 4);
    chk("t1_clk_fin_cycles", n_cfin, 1);
    chk("t1_post_delay", t_cfin - t_dfall, 3);
    chk("t1_busy_after_ack", t_idle - t_fack, 1);

    // Four contiguous beats
    clr_stats();
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0302, 1'b0);
    send_beat(16'h0504, 1'b0);
    send_beat(16'h0706, 1'b1);
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_idle();
    chk("t2_ready_count", n_rdy, 4);
    chk("t2_contiguous", last_rdy - first_rdy, 3);
    chk("t2_sb_drained", exp_q.size(), 0);

    // Underrun: valid dropped for one consume cycle
    clr_stats();
    send_beat(16'h1111, 1'b0);
    tx_valid = 1'b0;
    @(negedge clk_sys);
    chk("t3_underrun_pulse", underrun_err, 1'b1);
    chk("t3_underrun_lane_data", lane_data, 16'h0000);
    chk("t3_underrun_ready", tx_ready, 1'b0);
    @(posedge clk_sys); #1;
    send_beat(16'h2222, 1'b0);
    send_beat(16'h3333, 1'b1);
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_idle();
    chk("t3_underrun_count", n_under, 1);
    chk("t3_ready_count", n_rdy, 3);
    chk("t3_sb_drained", exp_q.size(), 0);

    // Back-to-back packets: second one waits for IDLE and a fresh clock start
    clr_stats();
    send_beat(16'h1234, 1'b0);
    send_beat(16'h5678, 1'b1);
    send_beat(16'h9ABC, 1'b0);
    send_beat(16'hDEF0, 1'b1);
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_idle();
    chk("t4_clk_start_count", n_cstart, 2);
    chk("t4_clk_fin_count", n_cfin, 2);
    chk("t4_ready_count", n_rdy, 4);
    chk("t4_sb_drained", exp_q.size(), 0);

    // Reset in STREAM
    clr_stats();
    tx_data = 16'h4444; tx_valid = 1'b1; tx_last = 1'b0;
    exp_q.push_back({1'b0, 16'h4444});
    n = 0;
    @(negedge clk_sys);
    while (!tx_ready && n < 300) begin @(negedge clk_sys); n++; end
    chk("t5_in_stream", tx_ready, 1'b1);
    #1;
    rst_n = 1'b0; tx_valid = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_tx_ready", tx_ready, 1'b0);
    chk("t5_rst_lane_data", lane_data, 16'h0000);
    chk("t5_rst_data_fin", data_fin_rqst, 1'b0);
    chk("t5_rst_data_start", data_start_rqst, 1'b0);
    chk("t5_rst_clk_start", clk_start_rqst, 1'b0);
    chk("t5_rst_clk_fin", clk_fin_rqst, 1'b0);
    chk("t5_rst_underrun", underrun_err, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    @(posedge clk_sys); #1;
    clr_stats();
    send_beat(16'h7788, 1'b1);
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_idle();
    chk("t5_after_rst_ready", n_rdy, 1);
    chk("t5_after_rst_sb", exp_q.size(), 0);

    // Instance B: minimum delays, single lane
    b_tx_data = 8'h5A; b_tx_valid = 1'b1; b_tx_last = 1'b1;
    @(negedge clk_sys);
    chk("b_clk_start", b_clk_start_rqst, 1'b1);
    @(posedge clk_sys); #1; b_clk_active = 1'b1;
    @(negedge clk_sys);
    chk("b_clk_start_width", b_clk_start_rqst, 1'b0);
    chk("b_busy", b_busy, 1'b1);
    @(posedge clk_sys); #1; b_clk_data_rqst = 1'b1;
    @(negedge clk_sys);
    chk("b_data_start_early", b_data_start_rqst, 1'b0);
    @(posedge clk_sys); #1;
    @(negedge clk_sys);
    chk("b_data_start", b_data_start_rqst, 1'b1);
    @(posedge clk_sys); #1; b_data_active = 1'b1; b_data_rqst = 1'b1;
    @(negedge clk_sys);
    chk("b_sync_ready", b_tx_ready, 1'b0);
    chk("b_sync_lane_data", b_lane_data, 8'h00);
    @(posedge clk_sys); #1;
    @(negedge clk_sys);
    chk("b_consume_ready", b_tx_ready, 1'b1);
    chk("b_lane_data", b_lane_data, 8'h5A);
    chk("b_data_fin", b_data_fin_rqst, 1'b1);
    @(posedge clk_sys); #1; b_tx_valid = 1'b0; b_data_rqst = 1'b0;
    @(negedge clk_sys);
    chk("b_clk_fin_early", b_clk_fin_rqst, 1'b0);
    @(posedge clk_sys); #1; b_data_active = 1'b0;
    @(negedge clk_sys);
    chk("b_clk_fin_idle_cycle", b_clk_fin_rqst, 1'b0);
    @(posedge clk_sys); #1;
    @(negedge clk_sys);
    chk("b_clk_fin", b_clk_fin_rqst, 1'b1);
    @(posedge clk_sys); #1; b_clk_fin_ack = 1'b1; b_clk_active = 1'b0;
    @(negedge clk_sys);
    chk("b_clk_fin_width", b_clk_fin_rqst, 1'b0);
    chk("b_busy_fin", b_busy, 1'b1);
    @(posedge clk_sys); #1; b_clk_fin_ack = 1'b0; b_clk_data_rqst = 1'b0;
    @(negedge clk_sys);
    chk("b_idle", b_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsi_hs_lanes_ctrl.md
Name: dsi_hs_lanes_ctrl

Overview:
Sequences one HS clock lane and LANES HS data lanes, each an instance of the existing HS lane block (clock lane built with MODE=1, data lanes with MODE=0), for one HS burst per packet.
- Start: clock lane first, then a pre-delay, then all data lanes together.
- Middle: streams packet beats from an upstream valid/ready source, one byte per lane per cycle.
- End: finishes the data lanes, applies a post-delay, then stops the clock lane.
Sits between the packet assembler and the lane instances.

Parameters:
LANES, 2, number of data lanes (1..4); one beat carries LANES bytes, byte k goes to lane k.
CLK_PRE_CYCLES, 4, clk_sys cycles between the first clk_data_rqst cycle and data_start_rqst (1..255).
CLK_POST_CYCLES, 3, clk_sys cycles between all data lanes inactive and clk_fin_rqst (1..255).

Ports:
clk_sys  in  1  system clock (byte clock)
rst_n  in  1  reset
tx_data  in  8*LANES  beat; byte k = bits [8k+7:8k]
tx_valid  in  1  beat valid; must stay high for the whole packet
tx_last  in  1  marks final beat of packet
tx_ready  out  1  beat accepted this cycle
busy  out  1  controller not in IDLE
underrun_err  out  1  one-cycle pulse: lanes consumed a byte while tx_valid was low
clk_start_rqst  out  1  clock lane start (1-cycle pulse)
clk_fin_rqst  out  1  clock lane finish (1-cycle pulse)
clk_data_rqst  in  1  clock lane data_rqst
clk_active  in  1  clock lane active
clk_fin_ack  in  1  clock lane fin_ack
clk_lane_data  out  8  constant 8'b01010101
data_start_rqst  out  1  common start for all data lanes (1-cycle pulse)
data_fin_rqst  out  1  common finish for all data lanes
data_rqst  in  LANES  per-lane data_rqst
data_active  in  LANES  per-lane active
lane_data  out  8*LANES  per-lane inp_data

Behaviour:
- Reset is asynchronous, active-low (rst_n). Clock is clk_sys.
- Reset values: all outputs 0 except clk_lane_data (constant 0x55). FSM enters IDLE; counters 0; drq_d 0.
- Reset mid-burst: everything returns to IDLE immediately. Lanes are reset by the same rst_n.
- States: IDLE, CLK_START, CLK_PRE, DATA_START, STREAM, DATA_WAIT, CLK_POST, CLK_FIN.
- IDLE: if tx_valid=1 and clk_active=0, go to CLK_START. clk_start_rqst = 1 on that transition cycle only.
- CLK_START: wait for clk_data_rqst=1. Then load pre-counter with CLK_PRE_CYCLES-1 and go to CLK_PRE.
- CLK_PRE: decrement the counter; at 0, go to DATA_START. data_start_rqst = 1 for exactly one cycle (the cycle the FSM is in DATA_START).
- DATA_START: go to STREAM next cycle.
- STREAM:
  - drq_d = registered data_rqst[0].
  - Consume cycle: data_rqst[0]=1 and drq_d=1. This is lane ACTIVE; the first data_rqst cycle is SYNC and is not a consume cycle.
  - tx_ready = consume & tx_valid.
  - lane_data = tx_data (combinational) when tx_ready, else 0.
  - Consume cycle with tx_valid=0: lane_data=0, underrun_err pulse, stay in STREAM.
  - data_fin_rqst = tx_ready & tx_last, combinational and coincident with the last beat. Then go to DATA_WAIT.
- DATA_WAIT: wait until data_active == 0 on all lanes (not just fin_ack). Then load post-counter with CLK_POST_CYCLES-1 and go to CLK_POST.
- CLK_POST: count to 0. Then clk_fin_rqst = 1 for one cycle and go to CLK_FIN.
- CLK_FIN: wait for clk_fin_ack=1 or clk_active=0, then go to IDLE.
- A new packet is only taken from IDLE; tx_ready=0 outside STREAM. Back-to-back packets each get a full clock start/stop sequence.
- Lanes are assumed in lock-step: only lane 0 data_rqst is used for consume timing. A mismatch on data_rqst lanes during STREAM has undefined data.
- busy = (state != IDLE).

Test Plan:
- LANES=2, CLK_PRE=4, CLK_POST=3; single beat 0xA1B2 with tx_last -> clk_start_rqst 1 cycle; data_start_rqst exactly 4 cycles after first clk_data_rqst; lane0=0xB2, lane1=0xA1 in the first consume cycle with data_fin_rqst=1 simultaneously; clk_fin_rqst 3 cycles after data_active==0; busy drops after clk_fin_ack.
- 4-beat packet 0x0100,0x0302,0x0504,0x0706 -> exactly 4 tx_ready cycles, contiguous; lane0 sees 00,02,04,06; lane1 sees 01,03,05,07; no byte during SYNC cycle.
- tx_valid dropped for 1 cycle mid-packet -> underrun_err 1-cycle pulse, lane_data=0x0000 that cycle, remaining beats still delivered in order.
- Second packet presented while in CLK_POST -> tx_ready stays 0 until IDLE; then a new clk_start_rqst and full sequence; both packets intact.
- rst_n asserted in STREAM -> all outputs 0 asynchronously, busy=0; after release, a new packet sends normally.
- LANES=1, CLK_PRE=1, CLK_POST=1 -> minimum delays honoured (data_start_rqst 1 cycle after first clk_data_rqst, clk_fin_rqst 1 cycle after lanes idle).
